// File: rtl/counter_modulo.sv
// Up/down modulo counter with parallel load, wrap/saturate boundary mode and
// terminal/overflow flags. Define COUNTER_MODULO_PRESCALE_EN to add an enable prescaler.
module counter_modulo #(
   parameter int Size       = 5,
   parameter int Modulus    = 2**Size,
   parameter int ResetValue = 0
`ifdef COUNTER_MODULO_PRESCALE_EN
   ,
   parameter int Prescale   = 4
`endif
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            enable,
   input  logic            up,
   input  logic            saturate,
   input  logic            load,
   input  logic [Size-1:0] load_value,
   output logic [Size-1:0] count,
   output logic            terminal,
   output logic            overflow
);

   localparam logic [Size:0]   ModW   = (Size+1)'(Modulus);
   localparam logic [Size:0]   LastW  = (Size+1)'(Modulus - 1);
   localparam logic [Size-1:0] ResetC = Size'(ResetValue);

   logic [Size:0]   countW;
   logic [Size:0]   upNext;
   logic [Size:0]   downNext;
   logic [Size:0]   loadW;
   logic            atTop;
   logic            atBottom;
   logic            atBoundary;
   logic [Size-1:0] loadClamped;
   logic            tick;
   logic [Size-1:0] nextCount;
   logic            nextTerminal;
   logic            nextOverflow;

   // Boundaries come from the widened arithmetic itself: the increment reaching
   // Modulus, or the decrement borrowing into the extra bit.
   always_comb begin
      countW      = {1'b0, count};
      loadW       = {1'b0, load_value};
      upNext      = countW + 1'b1;
      downNext    = countW - 1'b1;
      atTop       = (upNext == ModW);
      atBottom    = downNext[Size];
      atBoundary  = up ? atTop : atBottom;
      loadClamped = (loadW > LastW) ? LastW[Size-1:0] : load_value;
   end

`ifdef COUNTER_MODULO_PRESCALE_EN
   localparam int PsW = (Prescale > 1) ? $clog2(Prescale) : 1;
   localparam logic [PsW-1:0] PsLast = PsW'(Prescale - 1);

   logic [PsW-1:0] psCount;

   // Only every Prescale-th enabled cycle lets the main counter take a step.
   always_ff @(posedge clock) begin
      if (reset || load) begin
         psCount <= '0;
      end else if (enable) begin
         psCount <= (psCount == PsLast) ? '0 : psCount + 1'b1;
      end
   end

   assign tick = (psCount == PsLast);
`else
   assign tick = 1'b1;
`endif

   // Next-state selection in priority order load > enable > hold; reset is
   // applied in the register block.
   always_comb begin
      nextCount    = count;
      nextTerminal = 1'b0;
      nextOverflow = overflow;
      if (load) begin
         nextCount    = loadClamped;
         nextOverflow = 1'b0;
      end else if (enable && !tick) begin
         nextTerminal = terminal;
      end else if (enable) begin
         if (atBoundary) begin
            nextTerminal = 1'b1;
            nextOverflow = 1'b1;
            if (!saturate) begin
               nextCount = up ? '0 : LastW[Size-1:0];
            end
         end else begin
            nextCount = up ? upNext[Size-1:0] : downNext[Size-1:0];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count    <= ResetC;
         terminal <= 1'b0;
         overflow <= 1'b0;
      end else begin
         count    <= nextCount;
         terminal <= nextTerminal;
         overflow <= nextOverflow;
      end
   end

endmodule

// File: tb/tb_counter_modulo.sv
// Self-checking bench for counter_modulo (Size=5, Modulus=20, ResetValue=7):
// directed scenarios followed by random traffic, all checked against an arithmetic model.
module tb_counter_modulo;

   localparam int Size       = 5;
   localparam int Modulus    = 20;
   localparam int ResetValue = 7;
`ifdef COUNTER_MODULO_PRESCALE_EN
   localparam int TbPrescale = 3;
`else
   localparam int TbPrescale = 1;
`endif

   logic            clock = 1'b0;
   logic            reset;
   logic            enable;
   logic            up;
   logic            saturate;
   logic            load;
   logic [Size-1:0] load_value;
   logic [Size-1:0] count;
   logic            terminal;
   logic            overflow;

   int errors = 0;
   int checks = 0;

   int mCount;
   int mTerm;
   int mOvf;
   int mPs;

   counter_modulo #(
      .Size(Size),
      .Modulus(Modulus),
      .ResetValue(ResetValue)
`ifdef COUNTER_MODULO_PRESCALE_EN
      ,
      .Prescale(TbPrescale)
`endif
   ) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .up(up),
      .saturate(saturate),
      .load(load),
      .load_value(load_value),
      .count(count),
      .terminal(terminal),
      .overflow(overflow)
   );

   always #5 clock = ~clock;

   // Reference behaviour: modular arithmetic on plain integers.
   task automatic modelStep(input int r, input int en, input int u, input int s,
                            input int ld, input int lv);
      int boundary;
      if (r != 0) begin
         mCount = ResetValue; mTerm = 0; mOvf = 0; mPs = 0;
      end else if (ld != 0) begin
         mCount = (lv < Modulus) ? lv : Modulus - 1;
         mTerm = 0; mOvf = 0; mPs = 0;
      end else if (en != 0) begin
         mPs = mPs + 1;
         if (mPs == TbPrescale) begin
            mPs = 0;
            boundary = (u != 0) ? (mCount == Modulus - 1) : (mCount == 0);
            mTerm = boundary;
            if (boundary) mOvf = 1;
            if (!(boundary && s != 0))
               mCount = (mCount + ((u != 0) ? 1 : Modulus - 1)) % Modulus;
         end
      end else begin
         mTerm = 0;
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [Size-1:0] expCount;
      logic            expTerm;
      logic            expOvf;
      expCount = Size'(mCount);
      expTerm  = (mTerm != 0);
      expOvf   = (mOvf != 0);
      checks++;
      assert (count === expCount) else begin
         errors++;
         $error("[TB] FAIL %s count: got %0d expected %0d", tag, count, expCount);
      end
      checks++;
      assert (terminal === expTerm) else begin
         errors++;
         $error("[TB] FAIL %s terminal: got %0b expected %0b", tag, terminal, expTerm);
      end
      checks++;
      assert (overflow === expOvf) else begin
         errors++;
         $error("[TB] FAIL %s overflow: got %0b expected %0b", tag, overflow, expOvf);
      end
   endtask

   // Drive one cycle of inputs, clock it, advance the model and compare #1 later.
   task automatic applyStimulus(input int r, input int en, input int u, input int s,
                                input int ld, input int lv, input string tag);
      reset      = (r != 0);
      enable     = (en != 0);
      up         = (u != 0);
      saturate   = (s != 0);
      load       = (ld != 0);
      load_value = Size'(lv);
      @(posedge clock);
      modelStep(r, en, u, s, ld, lv);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      mCount = 0; mTerm = 0; mOvf = 0; mPs = 0;
      reset = 1'b1; enable = 1'b0; up = 1'b1; saturate = 1'b0;
      load = 1'b0; load_value = '0;
      @(negedge clock);

      applyStimulus(1, 0, 1, 0, 0, 0, "reset1");
      applyStimulus(1, 0, 1, 0, 0, 0, "reset2");

      applyStimulus(0, 0, 1, 0, 1, 0, "load0");
      for (int i = 0; i < 20 * TbPrescale; i++)
         applyStimulus(0, 1, 1, 0, 0, 0, "upWrap");
      applyStimulus(0, 0, 1, 0, 0, 0, "upWrapIdle");

      applyStimulus(0, 0, 0, 1, 1, 2, "load2");
      for (int i = 0; i < 4 * TbPrescale; i++)
         applyStimulus(0, 1, 0, 1, 0, 0, "downSat");

      applyStimulus(0, 1, 1, 0, 1, 25, "loadClamp");
      applyStimulus(0, 1, 1, 0, 0, 0, "afterClamp");

      applyStimulus(0, 0, 1, 0, 1, 12, "load12");
      applyStimulus(1, 1, 1, 0, 1, 3, "resetOverride");
      applyStimulus(0, 1, 1, 0, 0, 0, "resumeAfterReset");

      applyStimulus(0, 0, 1, 0, 1, 31, "loadMax");
      for (int i = 0; i < 3 * TbPrescale; i++)
         applyStimulus(0, 1, 1, 1, 0, 0, "upSat");

`ifdef COUNTER_MODULO_PRESCALE_EN
      applyStimulus(0, 0, 1, 0, 1, 0, "psLoad");
      for (int i = 0; i < 9; i++)
         applyStimulus(0, 1, 1, 0, 0, 0, "prescale");
`endif

      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 39) == 0) ? 1 : 0,
                       ($urandom_range(0, 3) != 0) ? 1 : 0,
                       int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 1)),
                       ($urandom_range(0, 15) == 0) ? 1 : 0,
                       int'($urandom_range(0, 31)),
                       "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
